// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational on pc_f; EX resolutions train the table on the clock edge.
module branch_predict_unit #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic [31:0] predictpc,
    output logic        predict_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_mispredict,
    output logic [15:0] mispredict_cnt
);

    localparam int          ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [29:0]           target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [15:0]           mispredict_cnt_q;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_BITS-1:0]   r_tag;
    logic                  r_hit;
    logic [1:0]            r_ctr;
    logic [1:0]            r_ctr_d;

    // Byte-offset bits carry no information for a word-aligned predictor.
    logic unused_bits;
    assign unused_bits = ^{pc_f[1:0], res_pc[1:0], res_target[1:0]};

    always_comb begin
        f_idx = pc_f[INDEX_BITS+1:2];
        f_tag = pc_f[31:INDEX_BITS+2];
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        // Gating on rst keeps outputs defined while the table is held in reset.
        predict_taken = rst && f_hit && ctr_q[f_idx][1];
        predictpc     = predict_taken ? {target_q[f_idx], 2'b00} : pc_f + 32'd4;
    end

    always_comb begin
        r_idx   = res_pc[INDEX_BITS+1:2];
        r_tag   = res_pc[31:INDEX_BITS+2];
        r_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        r_ctr   = ctr_q[r_idx];
        r_ctr_d = r_ctr;
        if (res_taken && r_ctr != 2'b11) begin
            r_ctr_d = r_ctr + 2'b01;
        end else if (!res_taken && r_ctr != 2'b00) begin
            r_ctr_d = r_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            mispredict_cnt_q <= '0;
        end else begin
            if (res_valid) begin
                if (r_hit) begin
                    ctr_q[r_idx] <= r_ctr_d;
                    if (res_taken) begin
                        target_q[r_idx] <= res_target[31:2];
                    end
                end else if (res_taken) begin
                    // Allocate on a taken miss, starting weakly taken.
                    valid_q[r_idx]  <= 1'b1;
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= res_target[31:2];
                    ctr_q[r_idx]    <= 2'b10;
                end
            end
            if (res_valid && res_mispredict && mispredict_cnt_q != 16'hFFFF) begin
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
            end
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;

endmodule
